// File: rtl/pulse_gen_type2_if.sv
// Timer-subsystem bus of pulse_gen_type2: configuration and base tick in, stage pulses and live counters out.
interface pulse_gen_type2_if #(
  parameter int NSTG = 3,
  parameter int WD   = 10
);
  logic                 cfg_en;
  logic                 cfg_clr;
  logic [NSTG*WD-1:0]   cfg_max;
  logic                 trigger;
  logic [NSTG-1:0]      pulse_o;
  logic [NSTG*WD-1:0]   cnt_o;

  modport master (
    output cfg_en,
    output cfg_clr,
    output cfg_max,
    output trigger,
    input  pulse_o,
    input  cnt_o
  );

  modport slave (
    input  cfg_en,
    input  cfg_clr,
    input  cfg_max,
    input  trigger,
    output pulse_o,
    output cnt_o
  );
endinterface

// File: rtl/pulse_gen_type2.sv
// Cascaded timebase divider, NSTG stages; pulse_o zero-latency, or +1 cycle with PULSE_GEN_REG_OUT_EN.
// No backpressure: trigger is a strobe and every enabled trigger cycle counts as one tick.
module pulse_gen_type2 #(
  parameter int NSTG    = 3,
  parameter int WD      = 10,
  parameter int DEF_MAX = 999
) (
  input  logic               clk,
  input  logic               reset_n,
  pulse_gen_type2_if.slave   bus
);

  if (NSTG < 1 || NSTG > 8) begin : g_bad_nstg
    $error("pulse_gen_type2: NSTG must be in 1..8");
  end
  if (DEF_MAX < 0 || DEF_MAX > (1 << WD) - 1) begin : g_bad_def_max
    $error("pulse_gen_type2: DEF_MAX does not fit in WD bits");
  end

  logic [NSTG-1:0] tin;
  logic [NSTG-1:0] tout;

  // reset_n gates the base tick so pulse_o reads 0 while reset is held
  assign tin[0] = bus.trigger & bus.cfg_en & ~bus.cfg_clr & reset_n;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    logic [WD-1:0] max_k;
    logic [WD-1:0] cnt_q;

    assign max_k = bus.cfg_max[k*WD +: WD];

    if (k > 0) begin : g_chain
      assign tin[k] = tout[k-1];
    end

    assign tout[k] = tin[k] & (cnt_q == '0);

    // ">=" rather than "==" so a terminal count lowered below cnt_q wraps on the next tick
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
      end else if (bus.cfg_clr) begin
        cnt_q <= '0;
      end else if (tin[k]) begin
        cnt_q <= (cnt_q >= max_k) ? '0 : cnt_q + WD'(1);
      end
    end

    assign bus.cnt_o[k*WD +: WD] = cnt_q;
  end

`ifdef PULSE_GEN_REG_OUT_EN
  logic [NSTG-1:0] pulse_q;

  // Not cleared by cfg_clr: a pulse raised in the cycle before a clear still emerges
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_q <= '0;
    end else begin
      pulse_q <= tout;
    end
  end

  assign bus.pulse_o = pulse_q;
`else
  assign bus.pulse_o = tout;
`endif

endmodule

// File: tb/tb_pulse_gen_type2.sv
// Directed self-checking bench for pulse_gen_type2 (both PULSE_GEN_REG_OUT_EN builds).
module tb_pulse_gen_type2;
  localparam int NSTG = 3;
  localparam int WD   = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  pulse_gen_type2_if #(.NSTG(NSTG), .WD(WD)) bus ();

  pulse_gen_type2 #(.NSTG(NSTG), .WD(WD), .DEF_MAX(999)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Observed value in the trigger cycle / the following idle cycle for an expected stage pulse vector
  function automatic logic [NSTG-1:0] obs_a(input logic [NSTG-1:0] e);
`ifdef PULSE_GEN_REG_OUT_EN
    return '0;
`else
    return e;
`endif
  endfunction

  function automatic logic [NSTG-1:0] obs_b(input logic [NSTG-1:0] e);
`ifdef PULSE_GEN_REG_OUT_EN
    return e;
`else
    return '0;
`endif
  endfunction

  // One clock cycle: drive trigger just after the edge, sample pulse_o mid-cycle, return at edge+1
  task automatic drive_cycle(input logic trig, output logic [NSTG-1:0] p);
    bus.trigger = trig;
    #2;
    p = bus.pulse_o;
    @(posedge clk);
    #1;
    bus.trigger = 1'b0;
  endtask

  task automatic tick_pair(output logic [NSTG-1:0] pa, output logic [NSTG-1:0] pb);
    drive_cycle(1'b1, pa);
    drive_cycle(1'b0, pb);
  endtask

  task automatic do_clear();
    logic [NSTG-1:0] p;
    bus.cfg_clr = 1'b1;
    drive_cycle(1'b0, p);
    bus.cfg_clr = 1'b0;
  endtask

  task automatic test_reset();
    bus.trigger = 1'b1;
    #3;
    n_total++;
    if (bus.cnt_o !== '0) $display("FAIL reset_cnt: got %0h expected 0", bus.cnt_o);
    else n_pass++;
    n_total++;
    if (bus.pulse_o !== '0) $display("FAIL reset_pulse: got %0b expected 0", bus.pulse_o);
    else n_pass++;
    bus.trigger = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [NSTG-1:0] pa, pb, e;
    int p1_cnt;
    p1_cnt = 0;
    bus.cfg_en  = 1'b1;
    bus.cfg_max = {10'd9, 10'd9, 10'd9};
    for (int n = 1; n <= 1000; n++) begin
      e[0] = ((n - 1) % 10) == 0;
      e[1] = ((n - 1) % 100) == 0;
      e[2] = (n == 1);
      tick_pair(pa, pb);
      p1_cnt += int'(pa[1]) + int'(pb[1]);
      n_total++;
      if (pa !== obs_a(e)) $display("FAIL basic_trig_cycle tick %0d: got %0b expected %0b", n, pa, obs_a(e));
      else n_pass++;
      n_total++;
      if (pb !== obs_b(e)) $display("FAIL basic_next_cycle tick %0d: got %0b expected %0b", n, pb, obs_b(e));
      else n_pass++;
      if (n == 357) begin
        n_total++;
        if (bus.cnt_o !== {10'd4, 10'd6, 10'd7})
          $display("FAIL basic_cnt_357: got %0h expected %0h", bus.cnt_o, {10'd4, 10'd6, 10'd7});
        else n_pass++;
      end
    end
    n_total++;
    if (bus.cnt_o !== '0) $display("FAIL basic_cnt_1000: got %0h expected 0", bus.cnt_o);
    else n_pass++;
    n_total++;
    if (p1_cnt !== 10) $display("FAIL basic_p1_count: got %0d expected 10", p1_cnt);
    else n_pass++;
  endtask

  task automatic test_passthrough();
    logic [NSTG-1:0] p;
    logic e0;
    bus.cfg_max = {10'd9, 10'd9, 10'd0};
    do_clear();
    for (int i = 0; i <= 8; i++) begin
`ifdef PULSE_GEN_REG_OUT_EN
      e0 = (i >= 1);
`else
      e0 = (i < 8);
`endif
      drive_cycle(i < 8, p);
      n_total++;
      if (p[0] !== e0) $display("FAIL passthru_pulse cycle %0d: got %0b expected %0b", i, p[0], e0);
      else n_pass++;
      n_total++;
      if (bus.cnt_o[WD-1:0] !== '0) $display("FAIL passthru_cnt0 cycle %0d: got %0d expected 0", i, bus.cnt_o[WD-1:0]);
      else n_pass++;
    end
  endtask

  task automatic test_enable();
    logic [NSTG-1:0] pa, pb, any, e;
    bus.cfg_max = {10'd9, 10'd9, 10'd9};
    do_clear();
    for (int i = 0; i < 7; i++) tick_pair(pa, pb);
    n_total++;
    if (bus.cnt_o[WD-1:0] !== 10'd7) $display("FAIL en_setup_cnt0: got %0d expected 7", bus.cnt_o[WD-1:0]);
    else n_pass++;
    bus.cfg_en = 1'b0;
    any = '0;
    for (int i = 0; i < 20; i++) begin
      tick_pair(pa, pb);
      any |= pa | pb;
    end
    n_total++;
    if (any !== '0) $display("FAIL en_off_pulse: got %0b expected 0", any);
    else n_pass++;
    n_total++;
    if (bus.cnt_o[WD-1:0] !== 10'd7) $display("FAIL en_off_cnt0: got %0d expected 7", bus.cnt_o[WD-1:0]);
    else n_pass++;
    bus.cfg_en = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      e = (t == 4) ? 3'b001 : 3'b000;
      tick_pair(pa, pb);
      n_total++;
      if ((pa | pb) !== e) $display("FAIL en_resume tick %0d: got %0b expected %0b", t, pa | pb, e);
      else n_pass++;
      if (t == 3) begin
        n_total++;
        if (bus.cnt_o[WD-1:0] !== '0) $display("FAIL en_resume_wrap: got %0d expected 0", bus.cnt_o[WD-1:0]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_clear();
    logic [NSTG-1:0] pa, pb;
    bus.cfg_max = {10'd9, 10'd9, 10'd9};
    do_clear();
    for (int i = 0; i < 7; i++) tick_pair(pa, pb);
    n_total++;
    if (bus.cnt_o !== {10'd1, 10'd1, 10'd7}) $display("FAIL clr_setup_cnt: got %0h expected %0h", bus.cnt_o, {10'd1, 10'd1, 10'd7});
    else n_pass++;
    bus.cfg_clr = 1'b1;
    drive_cycle(1'b1, pa);
    bus.cfg_clr = 1'b0;
    n_total++;
    if (pa !== '0) $display("FAIL clr_pulse: got %0b expected 0", pa);
    else n_pass++;
    n_total++;
    if (bus.cnt_o !== '0) $display("FAIL clr_cnt: got %0h expected 0", bus.cnt_o);
    else n_pass++;
    tick_pair(pa, pb);
    n_total++;
    if (pa !== obs_a(3'b111)) $display("FAIL clr_first_tick_a: got %0b expected %0b", pa, obs_a(3'b111));
    else n_pass++;
    n_total++;
    if (pb !== obs_b(3'b111)) $display("FAIL clr_first_tick_b: got %0b expected %0b", pb, obs_b(3'b111));
    else n_pass++;
  endtask

  task automatic test_max_lower();
    logic [NSTG-1:0] pa, pb;
    logic e0;
    bus.cfg_max = {10'd9, 10'd9, 10'd9};
    do_clear();
    for (int i = 0; i < 8; i++) tick_pair(pa, pb);
    n_total++;
    if (bus.cnt_o[WD-1:0] !== 10'd8) $display("FAIL lower_setup_cnt0: got %0d expected 8", bus.cnt_o[WD-1:0]);
    else n_pass++;
    bus.cfg_max = {10'd9, 10'd9, 10'd3};
    for (int j = 1; j <= 10; j++) begin
      e0 = (j >= 2) && (((j - 2) % 4) == 0);
      tick_pair(pa, pb);
      n_total++;
      if ((pa[0] | pb[0]) !== e0) $display("FAIL lower_pulse tick %0d: got %0b expected %0b", j, pa[0] | pb[0], e0);
      else n_pass++;
      if (j == 1) begin
        n_total++;
        if (bus.cnt_o[WD-1:0] !== '0) $display("FAIL lower_wrap_cnt0: got %0d expected 0", bus.cnt_o[WD-1:0]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_async_reset();
    logic [NSTG-1:0] pa, pb;
    bus.cfg_max = {10'd9, 10'd9, 10'd9};
    do_clear();
    for (int i = 0; i < 5; i++) tick_pair(pa, pb);
    n_total++;
    if (bus.cnt_o[WD-1:0] !== 10'd5) $display("FAIL arst_setup_cnt0: got %0d expected 5", bus.cnt_o[WD-1:0]);
    else n_pass++;
    bus.trigger = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    n_total++;
    if (bus.cnt_o !== '0) $display("FAIL arst_cnt: got %0h expected 0", bus.cnt_o);
    else n_pass++;
    n_total++;
    if (bus.pulse_o !== '0) $display("FAIL arst_pulse: got %0b expected 0", bus.pulse_o);
    else n_pass++;
    bus.trigger = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.cfg_en  = 1'b1;
    bus.cfg_clr = 1'b0;
    bus.trigger = 1'b0;
    bus.cfg_max = {10'd9, 10'd9, 10'd9};
    test_reset();
    test_basic();
    test_passthrough();
    test_enable();
    test_clear();
    test_max_lower();
    test_async_reset();
    test_basic();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_total);
    $fatal(1);
  end
endmodule
